// File: rtl/buzzer_sequencer.sv
// buzzer_sequencer
//   Plays a 16-entry note table on the Buzzer peripheral. Each entry holds a
//   note code (0 = rest) and a duration in ms. For every entry with a nonzero
//   duration the block writes FREQ, then TIME. It then waits for the Buzzer's
//   TIME countdown to reach zero. After each entry it inserts a silent gap of
//   gapMs milliseconds. When the table has been played it either loops back to
//   entry 0 or turns the tone off and pulses done. While busy, this block owns
//   the Buzzer's register-write port.
//
// Ports
//   clk, rstn          system clock, asynchronous active-low reset
//   tblWe/Addr/Data    note-table write port ([15:12] note, [11:0] ms)
//   start, stop        single-cycle start / abort pulses
//   loopEn             replay from entry 0 after the last entry
//   seqLen             entries to play (0..16; larger values clamp to 16)
//   gapMs              silent gap after each entry, in ms
//   bzTime             Buzzer TIME readback
//   bzAddrIn/Size/Data Buzzer write port (bzSize = 4'hF marks a write)
//   bzAddrOut          Buzzer read address, tied to TIME (1)
//   busy, curIdx, done status; done pulses only on normal completion
module buzzer_sequencer #(
  parameter int CLK_FRE   = 50000000,
  parameter int MS_CYCLES = CLK_FRE / 1000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        tblWe,
  input  logic [3:0]  tblAddr,
  input  logic [15:0] tblData,
  input  logic        start,
  input  logic        stop,
  input  logic        loopEn,
  input  logic [4:0]  seqLen,
  input  logic [7:0]  gapMs,
  input  logic [31:0] bzTime,
  output logic [7:0]  bzAddrIn,
  output logic [3:0]  bzSize,
  output logic [31:0] bzData,
  output logic [7:0]  bzAddrOut,
  output logic        busy,
  output logic [3:0]  curIdx,
  output logic        done
);

  // Wide enough for 255 * MS_CYCLES, so the loaded gap count never wraps.
  localparam int GW = 8 + $clog2(MS_CYCLES);
  localparam logic [GW-1:0] MS_W = GW'(MS_CYCLES);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_WFREQ  = 4'd2;
  localparam logic [3:0] S_WTIME  = 4'd3;
  localparam logic [3:0] S_SETTLE = 4'd4;
  localparam logic [3:0] S_WAIT   = 4'd5;
  localparam logic [3:0] S_GAP    = 4'd6;
  localparam logic [3:0] S_ADV    = 4'd7;
  localparam logic [3:0] S_FIN    = 4'd8;
  localparam logic [3:0] S_ABORT0 = 4'd9;
  localparam logic [3:0] S_ABORT1 = 4'd10;

  logic [3:0]    state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [3:0]    note_q, note_d;
  logic [11:0]   dur_q, dur_d;
  logic          settle_q, settle_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          zdone_q, zdone_d;

  // Note table. It is not reset, and it accepts writes in every state.
  logic [15:0] tbl_q [16];

  always_ff @(posedge clk) begin
    if (tblWe) tbl_q[tblAddr] <= tblData;
  end

  logic [15:0]   entry;
  logic [4:0]    len_eff;
  logic [4:0]    idx_nxt;
  logic [GW-1:0] gap_load;
  logic          stop_hit;

  assign entry    = tbl_q[idx_q];
  assign len_eff  = (seqLen > 5'd16) ? 5'd16 : seqLen;
  assign idx_nxt  = {1'b0, idx_q} + 5'd1;
  assign gap_load = GW'(gapMs) * MS_W;

  // An abort applies in any active state. It also applies in the same cycle
  // as an accepted start. It is not re-armed while an abort is already
  // running, so the two clean-up writes are always issued exactly once.
  assign stop_hit = stop &&
                    (((state_q != S_IDLE) && (state_q != S_ABORT0) &&
                      (state_q != S_ABORT1)) ||
                     ((state_q == S_IDLE) && start && (seqLen != 5'd0)));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    note_d   = note_q;
    dur_d    = dur_q;
    settle_d = settle_q;
    gap_d    = gap_q;
    zdone_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (seqLen == 5'd0) begin
            zdone_d = 1'b1;
          end else begin
            idx_d   = 4'd0;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        note_d = entry[15:12];
        dur_d  = entry[11:0];
        if (entry[11:0] == 12'd0) begin
          // A zero-length entry issues no bus writes. It only produces the gap.
          gap_d   = gap_load;
          state_d = S_GAP;
        end else begin
          state_d = S_WFREQ;
        end
      end
      S_WFREQ: state_d = S_WTIME;
      S_WTIME: begin
        settle_d = 1'b1;
        state_d  = S_SETTLE;
      end
      // Two cycles: the Buzzer updates TIME, then its readback register follows.
      S_SETTLE: begin
        if (settle_q) settle_d = 1'b0;
        else          state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (bzTime == 32'd0) begin
          gap_d   = gap_load;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_ADV;
        else             gap_d   = gap_q - 1'b1;
      end
      S_ADV: begin
        if (idx_nxt < len_eff) begin
          idx_d   = idx_q + 4'd1;
          state_d = S_FETCH;
        end else if (loopEn) begin
          idx_d   = 4'd0;
          state_d = S_FETCH;
        end else begin
          state_d = S_FIN;
        end
      end
      S_FIN:    state_d = S_IDLE;
      S_ABORT0: state_d = S_ABORT1;
      S_ABORT1: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (stop_hit) state_d = S_ABORT0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      idx_q    <= 4'd0;
      note_q   <= 4'd0;
      dur_q    <= 12'd0;
      settle_q <= 1'b0;
      gap_q    <= '0;
      zdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      note_q   <= note_d;
      dur_q    <= dur_d;
      settle_q <= settle_d;
      gap_q    <= gap_d;
      zdone_q  <= zdone_d;
    end
  end

  // The bus is decoded from the registered state. As a result, reset drives
  // it to zero immediately.
  always_comb begin
    bzSize   = 4'h0;
    bzAddrIn = 8'd0;
    bzData   = 32'd0;
    case (state_q)
      S_WFREQ: begin
        bzSize = 4'hF;
        bzData = {28'b0, note_q};
      end
      S_WTIME: begin
        bzSize   = 4'hF;
        bzAddrIn = 8'd1;
        bzData   = {20'b0, dur_q};
      end
      S_FIN, S_ABORT1: bzSize = 4'hF;
      S_ABORT0: begin
        bzSize   = 4'hF;
        bzAddrIn = 8'd1;
      end
      default: ;
    endcase
  end

  assign bzAddrOut = 8'd1;
  assign busy      = (state_q != S_IDLE);
  assign curIdx    = idx_q;
  assign done      = (state_q == S_FIN) || zdone_q;

endmodule

// File: tb/tb_buzzer_sequencer.sv
module tb_buzzer_sequencer;
  localparam int CLK_FRE = 10000;
  localparam int MS      = CLK_FRE / 1000;
  localparam int TMO     = 20000;

  logic        clk = 1'b0, rstn = 1'b0;
  logic        tblWe = 1'b0, start = 1'b0, stop = 1'b0, loopEn = 1'b0;
  logic [3:0]  tblAddr = 4'd0;
  logic [15:0] tblData = 16'd0;
  logic [4:0]  seqLen = 5'd0;
  logic [7:0]  gapMs = 8'd0;
  logic [31:0] bzTime;
  logic [7:0]  bzAddrIn, bzAddrOut;
  logic [3:0]  bzSize, curIdx;
  logic [31:0] bzData;
  logic        busy, done;

  buzzer_sequencer #(.CLK_FRE(CLK_FRE)) dut (
    .clk(clk), .rstn(rstn), .tblWe(tblWe), .tblAddr(tblAddr), .tblData(tblData),
    .start(start), .stop(stop), .loopEn(loopEn), .seqLen(seqLen), .gapMs(gapMs),
    .bzTime(bzTime), .bzAddrIn(bzAddrIn), .bzSize(bzSize), .bzData(bzData),
    .bzAddrOut(bzAddrOut), .busy(busy), .curIdx(curIdx), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Buzzer model. A TIME write loads a ms countdown with a fresh prescaler.
  // The readback register lags the countdown by one cycle.
  logic [31:0] tr;
  int          pres;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tr <= 32'd0; pres <= 0; bzTime <= 32'd0;
    end else begin
      bzTime <= tr;
      if (bzSize == 4'hF && bzAddrIn == 8'd1) begin
        tr <= bzData; pres <= 0;
      end else if (tr != 32'd0) begin
        if (pres == MS - 1) begin pres <= 0; tr <= tr - 32'd1; end
        else pres <= pres + 1;
      end
    end
  end

  typedef struct { logic [7:0] a; logic [31:0] d; logic [3:0] s; int c; } wr_t;
  typedef struct { logic [7:0] a; logic [31:0] d; int lo; int hi; } ex_t;
  wr_t wq[$];
  ex_t eq[$];
  int  dq[$];
  int  busy_seen = 0, idle_bad = 0;
  int  checks = 0, errors = 0;
  logic [15:0] tbl [16];

  always @(negedge clk) begin
    if (rstn) begin
      if (bzSize != 4'h0) wq.push_back('{a: bzAddrIn, d: bzData, s: bzSize, c: cyc});
      else if (bzAddrIn != 8'd0 || bzData != 32'd0) idle_bad++;
      if (done) dq.push_back(cyc);
      if (busy) busy_seen = 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic twrite(input int i, input logic [15:0] v);
    @(negedge clk);
    tblWe = 1'b1; tblAddr = 4'(i); tblData = v; tbl[i] = v;
    @(negedge clk);
    tblWe = 1'b0;
  endtask

  task automatic pulse_start(output int s);
    @(negedge clk);
    start = 1'b1; s = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_mon();
    wq.delete(); dq.delete(); busy_seen = 0;
  endtask

  task automatic pad(input int n);
    while (wq.size() < n) wq.push_back('{a: 8'hEE, d: 32'hDEADBEEF, s: 4'h0, c: -100000});
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (dq.size() == 0 && n < TMO) begin @(negedge clk); n++; end
    chk({tag, "_done_in_time"}, n < TMO, 1'b1);
  endtask

  // Reference: list of expected writes for the given passes over the table.
  // Each write has an allowed distance in cycles from the previous write (or
  // from the start pulse). The lower bound is all the ms work in between:
  // tone and gaps. Each table step adds at most a few control cycles.
  task automatic model(input int len_raw, input int passes, input int g);
    int len, n, acc, k;
    len = (len_raw > 16) ? 16 : len_raw;
    n = g * MS; acc = 0; k = 0;
    eq.delete();
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < len; i++) begin
        if (tbl[i][11:0] == 12'd0) begin
          acc += n; k++;
        end else begin
          eq.push_back('{a: 8'd0, d: {28'b0, tbl[i][15:12]}, lo: acc, hi: acc + 8 * (k + 1)});
          eq.push_back('{a: 8'd1, d: {20'b0, tbl[i][11:0]}, lo: 1, hi: 1});
          acc = int'(tbl[i][11:0]) * MS + n; k = 1;
        end
      end
    if (len > 0) eq.push_back('{a: 8'd0, d: 32'd0, lo: acc, hi: acc + 8 * (k + 1)});
  endtask

  task automatic compare(input string tag, input int s0);
    int prev, dl;
    chk({tag, "_nwrites"}, wq.size(), eq.size());
    pad(eq.size());
    for (int i = 0; i < eq.size(); i++) begin
      prev = (i == 0) ? s0 : wq[i-1].c;
      dl = wq[i].c - prev;
      chk($sformatf("%s_w%0d_addr", tag, i), wq[i].a, eq[i].a);
      chk($sformatf("%s_w%0d_data", tag, i), wq[i].d, eq[i].d);
      chk($sformatf("%s_w%0d_size", tag, i), wq[i].s, 4'hF);
      chk($sformatf("%s_w%0d_dt", tag, i),
          (dl >= eq[i].lo && dl <= eq[i].hi) ? eq[i].lo : dl, eq[i].lo);
    end
  endtask

  task automatic play(input string tag);
    int s0;
    model(int'(seqLen), 1, int'(gapMs));
    clear_mon();
    pulse_start(s0);
    wait_done(tag);
    tick(3);
    chk({tag, "_busy_end"}, busy, 1'b0);
    chk({tag, "_ndone"}, dq.size(), 1);
    compare(tag, s0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_size"}, bzSize, 4'h0);
    chk({tag, "_addrin"}, bzAddrIn, 8'd0);
    chk({tag, "_data"}, bzData, 32'd0);
    chk({tag, "_addrout"}, bzAddrOut, 8'd1);
    chk({tag, "_idx"}, curIdx, 4'd0);
  endtask

  initial begin
    int s0, sc, n, dc;
    for (int i = 0; i < 16; i++) tbl[i] = 16'd0;
    #12 check_reset("rst_held");
    @(negedge clk) rstn = 1'b1;
    tick(2);
    check_reset("rst_released");

    // Basic two-note sequence with a 1 ms gap.
    twrite(0, {4'd1, 12'd3}); twrite(1, {4'd8, 12'd2});
    seqLen = 5'd2; gapMs = 8'd1; loopEn = 1'b0;
    play("t1_basic");

    // Empty sequence: done exactly one cycle after start, never busy.
    seqLen = 5'd0;
    clear_mon();
    pulse_start(s0);
    tick(5);
    dc = (dq.size() > 0) ? dq[0] : -1;
    chk("t2_ndone", dq.size(), 1);
    chk("t2_done_cycle", dc, s0 + 1);
    chk("t2_nwrites", wq.size(), 0);
    chk("t2_busy_seen", busy_seen, 0);

    // Zero-duration entry: only the gap, then the FIN write.
    twrite(0, {4'd5, 12'd0});
    seqLen = 5'd1; gapMs = 8'd2;
    play("t3_dur0");

    // Looping, disabled during pass 2.
    twrite(0, {4'd3, 12'd2}); twrite(1, {4'd6, 12'd1});
    seqLen = 5'd2; gapMs = 8'd0; loopEn = 1'b1;
    model(2, 2, 0);
    clear_mon();
    pulse_start(s0);
    n = 0;
    while (wq.size() < 5 && n < TMO) begin @(negedge clk); n++; end
    chk("t4_pass2_in_time", n < TMO, 1'b1);
    chk("t4_idx_wrapped", curIdx, 4'd0);
    loopEn = 1'b0;
    wait_done("t4");
    tick(3);
    chk("t4_busy_end", busy, 1'b0);
    chk("t4_ndone", dq.size(), 1);
    compare("t4_loop", s0);

    // Stop mid-tone; a start while busy is ignored.
    twrite(0, {4'd9, 12'd5});
    seqLen = 5'd1; gapMs = 8'd0;
    clear_mon();
    pulse_start(s0);
    n = 0;
    while (wq.size() < 2 && n < TMO) begin @(negedge clk); n++; end
    chk("t5_tone_in_time", n < TMO, 1'b1);
    pulse_start(sc);
    n = 0;
    while (bzTime != 32'd2 && n < TMO) begin @(negedge clk); n++; end
    chk("t5_time2_in_time", n < TMO, 1'b1);
    chk("t5_busy_before_stop", busy, 1'b1);
    @(negedge clk);
    stop = 1'b1; sc = cyc;
    @(negedge clk);
    stop = 1'b0;
    chk("t5_busy_abort0", busy, 1'b1);
    tick(1);
    chk("t5_busy_abort1", busy, 1'b1);
    tick(1);
    chk("t5_busy_fell", busy, 1'b0);
    tick(3);
    chk("t5_nwrites", wq.size(), 4);
    pad(4);
    chk("t5_w0_addr", wq[0].a, 8'd0);
    chk("t5_w0_data", wq[0].d, 32'd9);
    chk("t5_w1_data", wq[1].d, 32'd5);
    chk("t5_w2_addr", wq[2].a, 8'd1);
    chk("t5_w2_data", wq[2].d, 32'd0);
    chk("t5_w2_cycle", wq[2].c, sc + 1);
    chk("t5_w3_addr", wq[3].a, 8'd0);
    chk("t5_w3_data", wq[3].d, 32'd0);
    chk("t5_w3_cycle", wq[3].c, sc + 2);
    chk("t5_ndone", dq.size(), 0);

    // Reset during the gap, then replay from entry 0.
    twrite(0, {4'd2, 12'd1});
    seqLen = 5'd1; gapMs = 8'd5;
    clear_mon();
    pulse_start(s0);
    n = 0;
    while (wq.size() < 2 && n < TMO) begin @(negedge clk); n++; end
    chk("t6_tone_in_time", n < TMO, 1'b1);
    tick(MS + 20);
    chk("t6_busy_in_gap", busy, 1'b1);
    @(negedge clk);
    rstn = 1'b0;
    #1 check_reset("t6_rst");
    chk("t6_ndone", dq.size(), 0);
    @(negedge clk) rstn = 1'b1;
    tick(2);
    play("t6_replay");

    // Randomized tables, lengths (including >16) and gaps.
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 16; i++)
        twrite(i, {4'($urandom_range(0, 15)), 12'($urandom_range(0, 3))});
      seqLen = 5'($urandom_range(0, 20));
      gapMs  = 8'($urandom_range(0, 2));
      loopEn = 1'b0;
      play($sformatf("rnd%0d", it));
    end

    chk("idle_bus_zero", idle_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
